pong_match_ctrl: RTL

Parametrised match-flow controller for the Pong game, sitting between the top-level pong wrapper and the movement game core. It sequences a match through idle, serve countdown, play, pause, point hold and game-over. It owns both scores and gates the game core through `play_en` and a one-cycle `ball_reset`. Win score, score width and all timing intervals are parameters, so the same block serves the DE2-115 build and fast simulation.

---
 rtl/pong_pkg.sv | 21 ++
 rtl/pong_timer.sv | 27 ++
 rtl/pong_match_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and codes for the pong match controller.
// State encoding is exported on the state port for debug LEDs.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_POINT = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  localparam logic SERVE_RIGHT = 1'b0;
  localparam logic SERVE_LEFT  = 1'b1;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/pong_timer.sv
// Loadable down-counter; done while the count sits at zero.
// Shared by serve countdown, point hold and the game-over blink.
module pong_timer #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-flow controller: serve, play, pause, point hold, game over.
// Owns both scores and gates the movement core via play_en/ball_reset.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 50_000_000,
  parameter int POINT_HOLD  = 25_000_000,
  parameter int CNT_W       = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause_toggle,
  input  logic               p1_point,
  input  logic               p2_point,
  output logic               play_en,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         winner,
  output logic [2:0]         state,
  output logic               blink
);

  localparam logic [CNT_W-1:0] SERVE_LD =
    CNT_W'(SERVE_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LD =
    CNT_W'(POINT_HOLD - 1);
  localparam logic [SCORE_W-1:0] WIN =
    SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE =
    SCORE_W'(1);

  state_t st, st_n;
  logic [SCORE_W-1:0] p1_n, p2_n;
  logic [1:0] win_n;
  logic dir_n, blink_n, ball_n;
  logic t_load, t_en, t_done;
  logic [CNT_W-1:0] t_val;

  pong_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .en       (t_en),
    .load_val (t_val),
    .done     (t_done)
  );

  always_comb begin
    st_n    = st;
    p1_n    = p1_score;
    p2_n    = p2_score;
    dir_n   = serve_dir;
    win_n   = winner;
    blink_n = blink;
    ball_n  = 1'b0;
    t_load  = 1'b0;
    t_en    = 1'b0;
    t_val   = SERVE_LD;
    unique case (st)
      ST_IDLE: begin
        if (start) begin
          p1_n   = '0;
          p2_n   = '0;
          st_n   = ST_SERVE;
          t_load = 1'b1;
          ball_n = 1'b1;
        end
      end
      ST_SERVE: begin
        if (t_done) st_n = ST_PLAY;
        else        t_en = 1'b1;
      end
      ST_PLAY: begin
        t_val = HOLD_LD;
        if (p1_point && p2_point) begin
          dir_n  = ~serve_dir;
          st_n   = ST_POINT;
          t_load = 1'b1;
        end else if (p1_point) begin
          p1_n   = p1_score + ONE;
          dir_n  = SERVE_RIGHT;
          st_n   = ST_POINT;
          t_load = 1'b1;
        end else if (p2_point) begin
          p2_n   = p2_score + ONE;
          dir_n  = SERVE_LEFT;
          st_n   = ST_POINT;
          t_load = 1'b1;
        end else if (pause_toggle) begin
          st_n = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_toggle) st_n = ST_PLAY;
      end
      ST_POINT: begin
        if (!t_done) begin
          t_en = 1'b1;
        end else if (p1_score == WIN) begin
          win_n  = WIN_P1;
          st_n   = ST_OVER;
          t_load = 1'b1;
          t_val  = HOLD_LD;
        end else if (p2_score == WIN) begin
          win_n  = WIN_P2;
          st_n   = ST_OVER;
          t_load = 1'b1;
          t_val  = HOLD_LD;
        end else begin
          st_n   = ST_SERVE;
          t_load = 1'b1;
          ball_n = 1'b1;
        end
      end
      ST_OVER: begin
        if (start) begin
          p1_n    = '0;
          p2_n    = '0;
          win_n   = WIN_NONE;
          blink_n = 1'b0;
          st_n    = ST_SERVE;
          t_load  = 1'b1;
          ball_n  = 1'b1;
        end else if (t_done) begin
          // reload so blink has a full half-period each phase
          blink_n = ~blink;
          t_load  = 1'b1;
          t_val   = HOLD_LD;
        end else begin
          t_en = 1'b1;
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= ST_IDLE;
      p1_score   <= '0;
      p2_score   <= '0;
      serve_dir  <= SERVE_RIGHT;
      winner     <= WIN_NONE;
      blink      <= 1'b0;
      ball_reset <= 1'b0;
      play_en    <= 1'b0;
    end else begin
      st         <= st_n;
      p1_score   <= p1_n;
      p2_score   <= p2_n;
      serve_dir  <= dir_n;
      winner     <= win_n;
      blink      <= blink_n;
      ball_reset <= ball_n;
      play_en    <= (st_n == ST_PLAY);
    end
  end

  assign state = st;

endmodule
